// File: rtl/aes_inv_round_ctrl.sv
// ============================================================================
// Module  : aes_inv_round_ctrl
// Brief   : Sequencer for an iterative AES inverse cipher (rounds NR down to 0).
// Revision: 1.0
// ============================================================================
`default_nettype none

module aes_inv_round_ctrl #(
    parameter int NR = 10
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        key_ready_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [3:0]  rk_addr_o,
    output logic        ld_input_o,
    output logic        round_en_o,
    output logic        last_round_o,
    output logic        busy_o,
    output logic        abort_o,
    output logic [15:0] blk_cnt_o
);

    localparam int RW = $clog2(NR + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ROUND = 3'd2,
        S_FINAL = 3'd3,
        S_HOLD  = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [RW-1:0]   rnd_q, rnd_d;
    logic [15:0]     blk_cnt_q;
    logic            ld_input_q, round_en_q, last_round_q;
    logic            busy_q, out_valid_q, abort_q;
    logic            accept, key_lost, done;

    // The abort cycle is already IDLE but must not accept a new block.
    assign in_ready_o = rst_ni && key_ready_i && (state_q == S_IDLE) && !abort_q;
    assign accept     = in_valid_i && in_ready_o;
    assign key_lost   = busy_q && !key_ready_i;
    assign done       = (state_q == S_HOLD) && out_ready_i;

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        case (state_q)
            S_IDLE: begin
                if (accept) state_d = S_INIT;
            end
            S_INIT: begin
                rnd_d   = RW'(NR - 1);
                state_d = (NR - 1 == 0) ? S_FINAL : S_ROUND;
            end
            S_ROUND: begin
                rnd_d = rnd_q - RW'(1);
                if (rnd_q == RW'(1)) state_d = S_FINAL;
            end
            S_FINAL: state_d = S_HOLD;
            S_HOLD: begin
                if (out_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (key_lost) begin
            state_d = S_IDLE;
            rnd_d   = '0;
        end
    end

    always_comb begin
        rk_addr_o = 4'd0;
        case (state_q)
            S_INIT:  rk_addr_o = 4'(NR);
            S_ROUND: rk_addr_o = 4'(rnd_q);
            default: rk_addr_o = 4'd0;
        endcase
    end

    // Strobes are decoded from the next state so they line up with state_q.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            rnd_q        <= '0;
            blk_cnt_q    <= 16'h0000;
            ld_input_q   <= 1'b0;
            round_en_q   <= 1'b0;
            last_round_q <= 1'b0;
            busy_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            rnd_q        <= rnd_d;
            ld_input_q   <= (state_d == S_INIT);
            round_en_q   <= (state_d == S_ROUND) || (state_d == S_FINAL);
            last_round_q <= (state_d == S_FINAL);
            busy_q       <= (state_d == S_INIT) || (state_d == S_ROUND) || (state_d == S_FINAL);
            out_valid_q  <= (state_d == S_HOLD);
            abort_q      <= key_lost;
            if (done) blk_cnt_q <= blk_cnt_q + 16'd1;
        end
    end

    assign ld_input_o   = ld_input_q;
    assign round_en_o   = round_en_q;
    assign last_round_o = last_round_q;
    assign busy_o       = busy_q;
    assign out_valid_o  = out_valid_q;
    assign abort_o      = abort_q;
    assign blk_cnt_o    = blk_cnt_q;

endmodule

`default_nettype wire

// File: doc/aes_inv_round_ctrl.md
# aes_inv_round_ctrl

Iterative sequencer for the AES inverse-cipher datapath: it accepts one ciphertext block per handshake, walks the shared inverse-round logic (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns) through rounds NR down to 0, and addresses the round-key store. It sits between the block-level input/output handshakes and the 128-bit state register and round-function mux. It owns no data: it drives only load, enable, select and key-address strobes.

## Interface
- NR, default 10: number of AES rounds; legal values 10, 12, 14.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- key_ready  in  1  round-key store holds a valid expanded schedule.
- in_valid  in  1  ciphertext block presented on the datapath input.
- in_ready  out  1  controller accepts a block this cycle.
- out_valid  out  1  plaintext in the state register is valid.
- out_ready  in  1  downstream consumes the plaintext.
- rk_addr  out  4  round-key index driven to the key store; combinational from state and counter.
- ld_input  out  1  state register loads ciphertext XOR rk[rk_addr].
- round_en  out  1  state register loads the inverse-round result.
- last_round  out  1  bypass InvMixColumns (final round).
- busy  out  1  block in flight (INIT, ROUND or FINAL).
- abort  out  1  one-cycle pulse: operation cancelled.
- blk_cnt  out  16  completed-block counter; wraps 0xFFFF to 0x0000.

## Operation
- States: IDLE, INIT, ROUND, FINAL, HOLD. Round counter rnd has width clog2(NR+1).
- IDLE: in_ready = key_ready. When in_valid and in_ready are both high, go to INIT.
- INIT: ld_input=1, rk_addr=NR, rnd set to NR-1. Next state is ROUND. If NR-1 were 0, the next state would be FINAL; this is never reached for legal NR.
- ROUND: round_en=1, last_round=0, rk_addr=rnd, rnd decrements each cycle. The cycle with rnd==1 transitions to FINAL.
- FINAL: round_en=1, last_round=1, rk_addr=0. Next state is HOLD.
- HOLD: out_valid=1. Stay in HOLD until out_ready is high. On that cycle, blk_cnt increments and the next state is IDLE.
- In states other than INIT, ROUND and FINAL: rk_addr=0, and ld_input, round_en and last_round are 0.
- key_ready low while in INIT, ROUND or FINAL: abort=1 on the following cycle and the state returns to IDLE. The datapath strobes for the abandoned block are not issued. out_valid is not asserted and blk_cnt is unchanged.
- key_ready low while in HOLD: no effect; the computed result stays valid.
- in_valid while not in IDLE: ignored; in_ready=0.
- out_ready while not in HOLD: ignored.
- rst_n low at any cycle, including mid-block: the next state is IDLE and all registers are cleared.

## Timing
- Reset values: state IDLE, rnd 0, blk_cnt 0x0000, abort 0. in_ready, out_valid, ld_input, round_en, last_round and busy are all 0, and rk_addr=0. in_ready follows key_ready from the first cycle after rst_n rises.
- Acceptance at cycle T:
  - T+1: INIT.
  - T+2 through T+NR: ROUND, with rk_addr = NR-1 down to 1.
  - T+NR+1: FINAL.
  - T+NR+2: out_valid first high.
- Latency from acceptance to out_valid is NR+2 cycles (12 for NR=10).
- Minimum initiation interval is NR+3 cycles, with out_ready held high.
- out_valid stays high, with the state register frozen, until out_ready is sampled high.
- All outputs are Moore, except in_ready (from key_ready) and rk_addr (from state and rnd).
- The abort pulse lasts exactly one cycle, in the cycle the state returns to IDLE. in_ready is 0 in that cycle.

## Test plan
- Single block: reset, key_ready=1, NR=10, FIPS-197 C.1 ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a. Accept at T. Required response:
  - ld_input high at T+1 with rk_addr=10.
  - rk_addr 9..1 on T+2..T+10.
  - last_round high only at T+11.
  - out_valid at T+12, datapath output 00112233445566778899aabbccddeeff, blk_cnt becomes 1 after out_ready.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Required: out_valid stays high, state output stable, in_ready=0 throughout. When out_ready rises, blk_cnt increments once.
- Back-to-back: in_valid and out_ready held high for 3 blocks. Required: acceptances at T, T+13, T+26 and blk_cnt=3.
- Key invalidated: drop key_ready at T+5. Required: abort pulse at T+6, state IDLE, no out_valid, blk_cnt unchanged. in_ready stays 0 until key_ready returns.
- Reset mid-operation: rst_n low at T+7 for 1 cycle. Required: the next cycle shows busy=0 and all outputs at reset values. A new block is then accepted and produces the correct result.
- NR=14 instance: rk_addr sequence 14,13..1,0, out_valid at T+16. Preload blk_cnt=0xFFFF via force, complete one block, and require blk_cnt=0x0000.
